// File: rtl/elevator_request_scheduler_if.sv
// Bundles the floor-call, controller-status and dispatch signals exchanged
// between the request scheduler and its environment.
interface elevator_request_scheduler_if #(
    parameter int FLOORS = 8
);
    logic [FLOORS-1:0] call_btn;
    logic [FLOORS-1:0] current_floor;
    logic              complete;
    logic              door_alert;
    logic              weight_alert;
    logic [FLOORS-1:0] request_floor;
    logic              req_valid;
    logic [FLOORS-1:0] pending;
    logic              dir_up;
    logic              busy;

    // master drives the buttons and controller status; slave is the scheduler
    modport master (
        output call_btn, current_floor, complete, door_alert, weight_alert,
        input  request_floor, req_valid, pending, dir_up, busy
    );

    modport slave (
        input  call_btn, current_floor, complete, door_alert, weight_alert,
        output request_floor, req_valid, pending, dir_up, busy
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls, dispatches one one-hot target at a time, retires it on arrival
// and dwells before the next dispatch. Define SCHED_SCAN_EN for SCAN (sweep) selection.
module elevator_request_scheduler #(
    parameter int                FLOORS       = 8,
    parameter int                DWELL_CYCLES = 16,
    parameter logic [FLOORS-1:0] RESET_FLOOR  = FLOORS'(8'h01)
) (
    input  logic                         clk,
    input  logic                         reset,
    elevator_request_scheduler_if.slave  bus
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_HOLD,
        ST_DWELL
    } state_t;

    state_t            state_reg, state_next;
    logic [FLOORS-1:0] pending_reg, pending_next;
    logic [FLOORS-1:0] request_reg, request_next;
    logic              valid_reg, valid_next;
    logic              dir_reg, dir_next;
    logic [CW-1:0]     dwell_reg, dwell_next;
    logic [FLOORS-1:0] clr;
    logic [FLOORS-1:0] target;
    logic              arrived;
    logic              alert;

    function automatic logic [FLOORS-1:0] lowest_bit(input logic [FLOORS-1:0] v);
        return v & (~v + FLOORS'(1));
    endfunction

    function automatic logic [FLOORS-1:0] highest_bit(input logic [FLOORS-1:0] v);
        logic [FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (v[i]) begin
                r = FLOORS'(1) << i;
            end
        end
        return r;
    endfunction

`ifdef SCHED_SCAN_EN
    // Every floor is at-or-above or at-or-below the current one, so the two
    // candidate sets together always cover the whole pending bitmap.
    logic [FLOORS-1:0] at_or_above;
    logic [FLOORS-1:0] at_or_below;
    logic [FLOORS-1:0] up_cand;
    logic [FLOORS-1:0] down_cand;

    generate
        for (genvar gi = 0; gi < FLOORS; gi++) begin : g_floor_cmp
            localparam logic [FLOORS-1:0] FLOOR_VAL = FLOORS'(1) << gi;
            assign at_or_above[gi] = (FLOOR_VAL >= bus.current_floor);
            assign at_or_below[gi] = (FLOOR_VAL <= bus.current_floor);
        end
    endgenerate

    assign up_cand   = pending_reg & at_or_above;
    assign down_cand = pending_reg & at_or_below;

    always_comb begin
        target = '0;
        if (dir_reg) begin
            target = (up_cand != '0) ? lowest_bit(up_cand) : highest_bit(down_cand);
        end else begin
            target = (down_cand != '0) ? highest_bit(down_cand) : lowest_bit(up_cand);
        end
    end
`else
    always_comb begin
        target = lowest_bit(pending_reg);
    end
`endif

    // request_reg is one-hot, so equality also rejects a non-one-hot current_floor
    assign arrived = bus.complete && (bus.current_floor == request_reg);
    assign alert   = bus.door_alert || bus.weight_alert;

    always_comb begin
        state_next   = state_reg;
        request_next = request_reg;
        valid_next   = valid_reg;
        dir_next     = dir_reg;
        dwell_next   = dwell_reg;
        clr          = '0;

        case (state_reg)
            ST_IDLE: begin
                if (pending_reg != '0) begin
                    if (target == bus.current_floor) begin
                        clr        = target;
                        dwell_next = CW'(DWELL_CYCLES - 1);
                        state_next = ST_DWELL;
                    end else begin
                        request_next = target;
                        valid_next   = 1'b1;
                        dir_next     = (target > bus.current_floor);
                        state_next   = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                if (alert) begin
                    state_next = ST_HOLD;
                end else if (arrived) begin
                    clr        = request_reg;
                    valid_next = 1'b0;
                    dwell_next = CW'(DWELL_CYCLES - 1);
                    state_next = ST_DWELL;
                end
            end
            ST_HOLD: begin
                if (!alert) begin
                    state_next = ST_SERVE;
                end
            end
            ST_DWELL: begin
                if (dwell_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    dwell_next = dwell_reg - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // clear wins over a same-cycle press at the retired floor
        pending_next = (pending_reg | bus.call_btn) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pending_reg <= '0;
            request_reg <= RESET_FLOOR;
            valid_reg   <= 1'b0;
            dir_reg     <= 1'b1;
            dwell_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            request_reg <= request_next;
            valid_reg   <= valid_next;
            dir_reg     <= dir_next;
            dwell_reg   <= dwell_next;
        end
    end

    assign bus.request_floor = request_reg;
    assign bus.req_valid     = valid_reg;
    assign bus.pending       = pending_reg;
    assign bus.dir_up        = dir_reg;
    assign bus.busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed scenarios followed by random traffic, every cycle compared against
// a floor-index reference model of the scheduling rules.
module tb_elevator_request_scheduler;
    localparam int DW = 5;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_HOLD  = 2;
    localparam int P_DWELL = 3;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_failed;
    int   cyc;

    elevator_request_scheduler_if #(.FLOORS(8)) ifc ();

    elevator_request_scheduler #(
        .FLOORS      (8),
        .DWELL_CYCLES(DW),
        .RESET_FLOOR (8'h01)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [7:0] m_pending;
    logic [7:0] m_req;
    logic       m_valid;
    logic       m_dir;
    int         m_phase;
    int         m_dwell;

    function automatic int pick_target(input logic [7:0] pend, input logic [7:0] cur, input logic dir);
        int best;
        best = -1;
`ifdef SCHED_SCAN_EN
        if (dir) begin
            for (int i = 0; i < 8; i++)
                if (best < 0 && pend[i] && ((8'd1 << i) >= cur)) best = i;
            for (int i = 7; i >= 0; i--)
                if (best < 0 && pend[i]) best = i;
        end else begin
            for (int i = 7; i >= 0; i--)
                if (best < 0 && pend[i] && ((8'd1 << i) <= cur)) best = i;
            for (int i = 0; i < 8; i++)
                if (best < 0 && pend[i]) best = i;
        end
`else
        if (dir || !dir) begin
            for (int i = 0; i < 8; i++)
                if (best < 0 && pend[i]) best = i;
        end
`endif
        return best;
    endfunction

    task automatic model_step(input logic rst, input logic [7:0] btn, input logic [7:0] cur,
                              input logic comp, input logic da, input logic wa);
        logic [7:0] clr;
        logic [7:0] t_vec;
        int         t;
        clr = 8'h00;
        if (rst) begin
            m_pending = 8'h00;
            m_req     = 8'h01;
            m_valid   = 1'b0;
            m_dir     = 1'b1;
            m_phase   = P_IDLE;
            m_dwell   = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (m_pending != 8'h00) begin
                        t     = pick_target(m_pending, cur, m_dir);
                        t_vec = 8'd1 << t;
                        if (t_vec == cur) begin
                            clr     = t_vec;
                            m_phase = P_DWELL;
                            m_dwell = DW - 1;
                        end else begin
                            m_req   = t_vec;
                            m_valid = 1'b1;
                            m_dir   = (t_vec > cur);
                            m_phase = P_SERVE;
                        end
                    end
                end
                P_SERVE: begin
                    if (da || wa) begin
                        m_phase = P_HOLD;
                    end else if (comp && cur == m_req) begin
                        clr     = m_req;
                        m_valid = 1'b0;
                        m_phase = P_DWELL;
                        m_dwell = DW - 1;
                    end
                end
                P_HOLD: begin
                    if (!da && !wa) m_phase = P_SERVE;
                end
                default: begin
                    if (m_dwell == 0) m_phase = P_IDLE;
                    else m_dwell--;
                end
            endcase
            m_pending = (m_pending | btn) & ~clr;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // one clock: drive inputs, advance model at the edge, compare #1 later
    task automatic tick(input logic rst, input logic [7:0] btn, input logic [7:0] cur,
                        input logic comp, input logic da, input logic wa);
        reset             = rst;
        ifc.call_btn      = btn;
        ifc.current_floor = cur;
        ifc.complete      = comp;
        ifc.door_alert    = da;
        ifc.weight_alert  = wa;
        @(posedge clk);
        model_step(rst, btn, cur, comp, da, wa);
        cyc++;
        #1;
        check("pending",       ifc.pending,            m_pending);
        check("request_floor", ifc.request_floor,      m_req);
        check("req_valid",     {7'd0, ifc.req_valid},  {7'd0, m_valid});
        check("dir_up",        {7'd0, ifc.dir_up},     {7'd0, m_dir});
        check("busy",          {7'd0, ifc.busy},       {7'd0, m_phase != P_IDLE});
    endtask

    task automatic idle_ticks(input int n, input logic [7:0] cur);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, cur, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic       r_rst;
        logic [7:0] r_btn;
        logic [7:0] r_cur;
        int         r;
        n_compared = 0;
        n_failed   = 0;
        cyc        = 0;
        m_pending  = 8'h00;
        m_req      = 8'h01;
        m_valid    = 1'b0;
        m_dir      = 1'b1;
        m_phase    = P_IDLE;
        m_dwell    = 0;

        // reset state, with a button press during reset that must be ignored
        tick(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        check("rst_pending", ifc.pending, 8'h00);
        check("rst_request", ifc.request_floor, 8'h01);
        check("rst_busy", {7'd0, ifc.busy}, 8'h00);
        check("rst_dir", {7'd0, ifc.dir_up}, 8'h01);
        $display("step: reset done");

        // press floor 4 at floor 0; dispatch two cycles after the press
        tick(1'b0, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
        check("press_visible", ifc.pending, 8'h10);
        check("no_early_valid", {7'd0, ifc.req_valid}, 8'h00);
        tick(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        check("dispatch_req", ifc.request_floor, 8'h10);
        check("dispatch_valid", {7'd0, ifc.req_valid}, 8'h01);
        check("dispatch_dir", {7'd0, ifc.dir_up}, 8'h01);
        $display("step: dispatched to 8'h10");

        // stale complete at the wrong floor must not retire
        tick(1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0);
        check("stale_pending", ifc.pending, 8'h10);
        $display("step: stale complete ignored");

        // weight alert for 5 cycles; arrival during HOLD must not retire
        tick(1'b0, 8'h02, 8'h10, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b1);
        check("hold_req", ifc.request_floor, 8'h10);
        check("hold_pending", ifc.pending, 8'h12);
        check("hold_valid", {7'd0, ifc.req_valid}, 8'h01);
        tick(1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
        check("retire_pending", ifc.pending, 8'h02);
        check("retire_valid", {7'd0, ifc.req_valid}, 8'h00);
        idle_ticks(DW - 1, 8'h10);
        check("dwell_busy", {7'd0, ifc.busy}, 8'h01);
        idle_ticks(1, 8'h10);
        check("dwell_done", {7'd0, ifc.busy}, 8'h00);
        $display("step: hold, retire and dwell checked");

        // pending floor 1 dispatches downward
        idle_ticks(1, 8'h10);
        check("down_req", ifc.request_floor, 8'h02);
        check("down_dir", {7'd0, ifc.dir_up}, 8'h00);
        tick(1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
        idle_ticks(DW, 8'h02);
        $display("step: served 8'h02 downward");

        // call at the current floor while idle: absorbed without dispatch
        tick(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        check("self_pending", ifc.pending, 8'h00);
        check("self_valid", {7'd0, ifc.req_valid}, 8'h00);
        check("self_busy", {7'd0, ifc.busy}, 8'h01);
        idle_ticks(DW, 8'h01);
        $display("step: same-floor call absorbed");

        // selection policy: at floor 3 heading up with calls at 1 and 7
        tick(1'b1, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h82, 8'h08, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
`ifdef SCHED_SCAN_EN
        check("policy_first", ifc.request_floor, 8'h80);
`else
        check("policy_first", ifc.request_floor, 8'h02);
`endif
        tick(1'b0, 8'h00, m_req, 1'b1, 1'b0, 1'b0);
        idle_ticks(DW + 1, m_req);
`ifdef SCHED_SCAN_EN
        check("policy_second", ifc.request_floor, 8'h02);
        check("policy_reverse", {7'd0, ifc.dir_up}, 8'h00);
`else
        check("policy_second", ifc.request_floor, 8'h80);
`endif
        $display("step: selection policy checked");

        // reset mid-DWELL with calls pending
        tick(1'b0, 8'h00, m_req, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'hF0, m_req, 1'b0, 1'b0, 1'b0);
        check("pre_reset_pending", ifc.pending, 8'hF0);
        tick(1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        check("midreset_pending", ifc.pending, 8'h00);
        check("midreset_req", ifc.request_floor, 8'h01);
        check("midreset_busy", {7'd0, ifc.busy}, 8'h00);
        $display("step: reset during dwell checked");

        // random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            r_rst = ($urandom_range(0, 249) == 0);
            r_btn = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            r = $urandom_range(0, 9);
            if (r < 5)      r_cur = m_req;
            else if (r < 8) r_cur = 8'h01 << $urandom_range(0, 7);
            else            r_cur = 8'($urandom);
            tick(r_rst, r_btn, r_cur, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end
        $display("step: random traffic done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Upstream request stage for the elevator controller. Latches floor-call buttons into a pending bitmap, chooses the next target floor, and drives it as the one-hot `request_floor` the controller consumes. It retires a call once the controller reports arrival at that floor, inserts a door-dwell period, then dispatches the next call. It freezes while the controller raises a door or weight alert.

## Interface
Parameters:
- `FLOORS`, 8: number of floors; width of every one-hot floor bus.
- `DWELL_CYCLES`, 16: cycles spent in DWELL after a call is retired, ≥1.
- `RESET_FLOOR`, 8'h01: value of `request_floor` after reset.

Ports:
- `clk`, input, 1: the single clock; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `call_btn`, input, FLOORS: button pulses; multi-hot allowed; bit i = floor i.
- `current_floor`, input, FLOORS: one-hot current floor from the controller's `out_current_floor`.
- `complete`, input, 1: controller arrival/stop flag.
- `door_alert`, input, 1: controller door-overtime alert.
- `weight_alert`, input, 1: controller overload alert.
- `request_floor`, output, FLOORS: one-hot target floor to the controller; registered.
- `req_valid`, output, 1: high while a dispatched target is being served, in SERVE or HOLD.
- `pending`, output, FLOORS: latched, unserved calls.
- `dir_up`, output, 1: current sweep direction; 1 = up.
- `busy`, output, 1: high when the state is not IDLE.

## Operation
- Reset values (registered on the edge where `reset`=1): `pending`=0, `request_floor`=RESET_FLOOR, `req_valid`=0, `dir_up`=1, `busy`=0, state=IDLE, dwell counter=0.
- Every cycle, `pending` <= (`pending` | `call_btn`) & ~`clr`. `clr` is the one-hot retire mask.
- Simultaneous set and clear of the same bit: clear wins. A press at the floor being retired is absorbed.
- Floor order is the numeric order of the one-hot values, so a higher bit means a higher floor. Comparisons are unsigned on FLOORS bits.
- A non-one-hot `current_floor` makes arrival detection false. The block waits; it does not error.

States:
- IDLE: if `pending`==0, stay. Otherwise select target T.
  - If T == `current_floor`: set `clr`=T and go to DWELL. No dispatch occurs.
  - Else: `request_floor` <= T, `req_valid` <= 1, `dir_up` <= (T > `current_floor`), go to SERVE.
- SERVE:
  - If `door_alert` or `weight_alert`: go to HOLD.
  - Else if `complete` && `current_floor` == `request_floor`: `clr` = `request_floor`, `req_valid` <= 0, load the dwell counter with DWELL_CYCLES-1, go to DWELL.
  - Both conditions are required because `complete` may be stale from a previous stop.
- HOLD: `request_floor` and `pending` set-path unchanged; calls still latch. Return to SERVE on the first cycle both alerts are 0.
- DWELL: decrement the counter; at 0 go to IDLE. Calls still latch.
- `request_floor` changes only on the IDLE→SERVE transition. It is stable through SERVE, HOLD, DWELL and IDLE.

## Timing
- A button press on cycle N is visible in `pending` at N+1.
- First selection can occur in IDLE at N+1; `request_floor`/`req_valid` update at N+2.
- Arrival detected on cycle A: `pending` bit clears and `req_valid` falls at A+1. DWELL occupies A+1..A+DWELL_CYCLES. IDLE is re-entered at A+DWELL_CYCLES+1.
- Minimum spacing between two dispatches: DWELL_CYCLES+2 cycles.
- Reset asserted mid-SERVE, HOLD or DWELL: all outputs return to reset values on that edge, and in-flight calls are discarded.
- `call_btn` asserted in the reset cycle is ignored.

## Configuration
- `SCHED_SCAN_EN` defined: SCAN selection.
  - T is the nearest pending floor strictly in direction `dir_up` from `current_floor` (a floor equal to `current_floor` counts in either direction).
  - If there is none, reverse direction and take the nearest pending floor the other way.
- `SCHED_SCAN_EN` undefined: fixed priority. T is the lowest-index set bit of `pending`. `dir_up` is still updated at dispatch.

## Test plan
- Reset, then `call_btn`=8'h10 with `current_floor`=8'h01: `request_floor`=8'h10 and `req_valid`=1 two cycles after the press; `dir_up`=1. Hold `complete`=1 with `current_floor`=8'h10: `pending`=0 next cycle, and IDLE after DWELL_CYCLES.
- In SERVE to 8'h10, raise `weight_alert` for 5 cycles while pressing 8'h02: state is HOLD, `request_floor` stays 8'h10, `pending`=8'h12; SERVE resumes when the alert drops.
- Stale `complete`=1 with `current_floor`=8'h04 while the target is 8'h10: no retire; `pending` bit 4 stays set.
- Press 8'h01 while idle at `current_floor`=8'h01: no dispatch, `req_valid` stays 0, `pending` clears, DWELL entered.
- With `SCHED_SCAN_EN`: at 8'h08, `dir_up`=1, pending 8'h82: serves 8'h80 first, then reverses to 8'h02. Without it: serves 8'h02 first.
- Assert `reset` mid-DWELL with `pending`=8'hF0: next cycle `pending`=0, `request_floor`=8'h01, `busy`=0.
